data_bus_io_bridge: RTL and testbench
=====================================

Name: data_bus_io_bridge

Overview:
- Sits directly downstream of the pipelined processor's data-memory interface (memory_write_enable / memory_addr / memory_in / memory_out).
- Splits that single data bus between the synchronous data RAM and a small block of memory-mapped I/O registers: a byte TX FIFO with a ready/valid drain port, a status register, a free-running timer and a scratch register.
- Preserves the processor's one-cycle read latency: the address is presented in one cycle and the data is consumed by the next stage in the following cycle.

Parameters:
- ADDR_SIZE, 18, address width.
- WORD_SIZE, 18, data word width.
- IO_BASE, 18'h3FFF0, base of the 16-word I/O window. Must be 16-aligned.
- FIFO_DEPTH_LOG2, 3, TX FIFO depth is 2^FIFO_DEPTH_LOG2 (default 8).

Ports:
- clock  in  1  single system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- cpu_write_enable  in  1  write strobe from the processor.
- cpu_addr  in  ADDR_SIZE  data address from the processor.
- cpu_in  in  WORD_SIZE  write data from the processor.
- cpu_out  out  WORD_SIZE  read data to the processor, valid one cycle after cpu_addr.
- ram_write_enable  out  1  RAM write strobe.
- ram_addr  out  ADDR_SIZE  RAM address.
- ram_in  out  WORD_SIZE  RAM write data.
- ram_out  in  WORD_SIZE  RAM read data, registered inside the RAM (1-cycle latency).
- tx_valid  out  1  FIFO head byte available.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts the head byte this cycle.

Behaviour:
- io_hit = (cpu_addr[ADDR_SIZE-1:4] == IO_BASE[ADDR_SIZE-1:4]); offset = cpu_addr[3:0].
- RAM path is combinational: ram_addr = cpu_addr; ram_in = cpu_in; ram_write_enable = cpu_write_enable & ~io_hit. I/O writes never reach the RAM.
- Read path:
  - Each cycle, register sel_io <= io_hit and io_rdata <= the I/O register value selected by offset in that cycle (pre-update value).
  - cpu_out = sel_io ? io_rdata : ram_out.
  - Reads have no side effects.
- Register map (offsets):
  - 0 TX_DATA: write pushes cpu_in[7:0]; reads return 0.
  - 1 STATUS (read): bit0 empty, bit1 full, bit2 overflow (sticky), bits[3+FIFO_DEPTH_LOG2:3] fill count; other bits 0. Writing 1 to bit2 clears overflow; all other written bits are ignored.
  - 2 TIMER: read returns the counter value; write loads cpu_in.
  - 3 SCRATCH: plain read/write register.
  - 4..15: reads return 0, writes are ignored.
- TX FIFO:
  - Circular buffer with read/write pointers of FIFO_DEPTH_LOG2 bits that wrap modulo depth, plus a count of FIFO_DEPTH_LOG2+1 bits.
  - tx_valid = (count != 0); tx_data = head entry; pop when tx_valid & tx_ready.
  - Push when not full: the byte is stored and count increments.
  - Push when full and no pop in the same cycle: the byte is dropped and overflow is set to 1.
  - Push when full with a pop in the same cycle: the push is accepted, count stays at depth, no overflow.
  - Push when empty: tx_valid rises the next cycle. There is no fall-through.
  - Overflow set and overflow clear in the same cycle: set wins.
- TIMER:
  - WORD_SIZE-bit counter incrementing every cycle; wraps from all-ones to 0.
  - A write in the same cycle wins: the next value is cpu_in exactly, not cpu_in+1.
- Reset (synchronous):
  - count=0, pointers=0, overflow=0, TIMER=0, SCRATCH=0, sel_io=0, io_rdata=0.
  - Hence tx_valid=0 and cpu_out=ram_out in the cycle after reset.
  - FIFO contents are not reset.
  - Reset mid-operation discards queued bytes and any pending I/O read.
- Writes and reads are single-cycle; the bridge never stalls the processor.

Test Plan:
- RAM passthrough:
  - Write 18'h12345 to addr 0x00010, then read 0x00010 → ram_write_enable=1 only on the write cycle; cpu_out=18'h12345 one cycle after the read address.
  - Any write to 0x3FFF3 → ram_write_enable stays 0.
- FIFO fill/overflow (tx_ready=0):
  - Write bytes 0x01..0x09 to 0x3FFF0 → after 8 pushes STATUS reads full=1, count=8, overflow=0.
  - 9th push → overflow=1, head still 0x01.
  - Write STATUS with bit2=1 → overflow reads 0.
- FIFO drain and wrap:
  - Hold tx_ready=1, push 12 bytes spread over time → tx_data sequence matches push order across pointer wrap-around; empty=1 at the end.
- Simultaneous full push+pop:
  - FIFO full, tx_ready=1, push 0xAA in the same cycle → count stays 8, overflow=0, 0xAA emerges after the 7 older bytes.
- Timer:
  - Write 18'h3FFFE to 0x3FFF2; read 0x3FFF2 on the next two cycles → reads return 3FFFE then 3FFFF; the value wraps to 0 the following cycle.
  - Write and read issued in the same cycle → the read returns the pre-write value.
- Reset mid-stream:
  - Reset with 5 bytes queued and an I/O read pending → next cycle tx_valid=0, STATUS count=0, TIMER=0, cpu_out=ram_out.

Source files
------------

// File: rtl/data_bus_io_bridge.sv
// Data-bus bridge: splits the CPU data port between the synchronous RAM and
// a 16-word memory-mapped I/O window (TX FIFO, status, timer, scratch).
module data_bus_io_bridge #(
    parameter int                    ADDR_SIZE       = 18,
    parameter int                    WORD_SIZE       = 18,
    parameter logic [ADDR_SIZE-1:0]  IO_BASE         = 18'h3FFF0,
    parameter int                    FIFO_DEPTH_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_write_enable,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_in,
    output logic [WORD_SIZE-1:0] cpu_out,
    output logic                 ram_write_enable,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_in,
    input  logic [WORD_SIZE-1:0] ram_out,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    logic                       io_hit;
    logic [3:0]                 offset;
    logic                       io_wr;
    logic                       push;
    logic                       pop;
    logic                       accept;
    logic                       full;
    logic                       empty;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [CW-1:0]              count;
    logic                       overflow;
    logic [WORD_SIZE-1:0]       timer;
    logic [WORD_SIZE-1:0]       scratch;
    logic [WORD_SIZE-1:0]       status;
    logic [WORD_SIZE-1:0]       rd_val;
    logic [WORD_SIZE-1:0]       io_rdata;
    logic                       sel_io;

    assign io_hit = cpu_addr[ADDR_SIZE-1:4] == IO_BASE[ADDR_SIZE-1:4];
    assign offset = cpu_addr[3:0];
    assign io_wr  = cpu_write_enable & io_hit;

    assign ram_addr         = cpu_addr;
    assign ram_in           = cpu_in;
    assign ram_write_enable = cpu_write_enable & ~io_hit;

    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign tx_valid = ~empty;
    assign tx_data  = mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    assign push     = io_wr & (offset == 4'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
    assign accept   = push & (~full | pop);

    always_comb begin
        status                       = '0;
        status[0]                    = empty;
        status[1]                    = full;
        status[2]                    = overflow;
        status[3+FIFO_DEPTH_LOG2:3]  = count;
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            4'd1:    rd_val = status;
            4'd2:    rd_val = timer;
            4'd3:    rd_val = scratch;
            default: rd_val = '0;
        endcase
    end

    assign cpu_out = sel_io ? io_rdata : ram_out;

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= cpu_in[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            timer    <= '0;
            scratch  <= '0;
            sel_io   <= 1'b0;
            io_rdata <= '0;
        end else begin
            sel_io   <= io_hit;
            io_rdata <= rd_val;
            if (pop)    rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            if (accept) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            count <= count + CW'(accept) - CW'(pop);
            if (push & full & ~pop)
                overflow <= 1'b1;
            else if (io_wr & (offset == 4'd1) & cpu_in[2])
                overflow <= 1'b0;
            if (io_wr & (offset == 4'd2))
                timer <= cpu_in;
            else
                timer <= timer + WORD_SIZE'(1);
            if (io_wr & (offset == 4'd3))
                scratch <= cpu_in;
        end
    end
endmodule

// File: tb/tb_data_bus_io_bridge.sv
// Bench for data_bus_io_bridge: directed table, hand sequences and random
// traffic checked against a queue-based model of the register map and RAM.
module tb_data_bus_io_bridge;
    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_write_enable;
    logic [17:0] cpu_addr;
    logic [17:0] cpu_in;
    logic [17:0] cpu_out;
    logic        ram_write_enable;
    logic [17:0] ram_addr;
    logic [17:0] ram_in;
    logic [17:0] ram_out = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    data_bus_io_bridge dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_write_enable (cpu_write_enable),
        .cpu_addr         (cpu_addr),
        .cpu_in           (cpu_in),
        .cpu_out          (cpu_out),
        .ram_write_enable (ram_write_enable),
        .ram_addr         (ram_addr),
        .ram_in           (ram_in),
        .ram_out          (ram_out),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready)
    );

    always #5 clock = ~clock;

    // Synchronous RAM with one-cycle registered read, old data on collision.
    logic [17:0] ram_mem [256] = '{default: '0};
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_addr[7:0]] <= ram_in;
        ram_out <= ram_mem[ram_addr[7:0]];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: byte queue, sticky flag, counters, shadow RAM.
    logic [7:0]  m_q [$];
    bit          m_ovf   = 0;
    logic [17:0] m_tmr   = '0;
    logic [17:0] m_scr   = '0;
    logic [17:0] m_pend  = '0;
    bit          m_known = 0;
    logic [17:0] m_ram [256] = '{default: '0};

    function automatic logic [17:0] m_io(input logic [3:0] off);
        int n;
        n = m_q.size();
        case (off)
            4'd1:    return 18'(n * 8 + int'(m_ovf) * 4
                            + (n == 8 ? 2 : 0) + (n == 0 ? 1 : 0));
            4'd2:    return m_tmr;
            4'd3:    return m_scr;
            default: return 18'd0;
        endcase
    endfunction

    logic [17:0] o_co;
    logic        o_tv;
    logic [7:0]  o_td;
    logic        o_rw;

    task automatic step(input bit rst, input bit we, input logic [17:0] a,
                        input logic [17:0] d, input bit rdy);
        bit         hit;
        bit         pop;
        bit         full;
        logic [3:0] off;
        hit = a[17:4] == 14'h3FFF;
        off = a[3:0];
        reset            = rst;
        cpu_write_enable = we;
        cpu_addr         = a;
        cpu_in           = d;
        tx_ready         = rdy;
        #3;
        o_co = cpu_out;
        o_tv = tx_valid;
        o_td = tx_data;
        o_rw = ram_write_enable;
        if (!rst) begin
            if (m_known) chk("cpu_out", cpu_out, m_pend);
            chk("tx_valid", tx_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
            chk("ram_we", ram_write_enable, we && !hit);
            chk("ram_addr", ram_addr, a);
            chk("ram_in", ram_in, d);
        end
        @(posedge clock);
        m_pend  = (hit && !rst) ? m_io(off) : m_ram[a[7:0]];
        m_known = 1;
        if (we && !hit) m_ram[a[7:0]] = d;
        if (rst) begin
            m_q.delete();
            m_ovf = 0;
            m_tmr = '0;
            m_scr = '0;
        end else begin
            pop  = m_q.size() != 0 && rdy;
            full = m_q.size() == 8;
            if (pop) void'(m_q.pop_front());
            if (we && hit && off == 4'd0) begin
                if (!full || pop) m_q.push_back(d[7:0]);
                else m_ovf = 1;
            end
            if (we && hit && off == 4'd1 && d[2]) m_ovf = 0;
            if (we && hit && off == 4'd3) m_scr = d;
            m_tmr = (we && hit && off == 4'd2) ? d : m_tmr + 18'd1;
        end
        #1;
    endtask

    task automatic wr(input logic [3:0] off, input logic [17:0] d,
                      input bit rdy);
        step(0, 1, {14'h3FFF, off}, d, rdy);
    endtask

    task automatic rd(input logic [3:0] off, output logic [17:0] v);
        step(0, 0, {14'h3FFF, off}, '0, 0);
        step(0, 0, 18'h00020, '0, 0);
        v = o_co;
    endtask

    typedef struct {
        bit          we;
        logic [17:0] a;
        logic [17:0] d;
        bit          cm;
        logic [17:0] co;
        bit          tm;
        bit          tv;
        bit          rw;
    } vec_t;

    function automatic vec_t v(input bit we, input logic [17:0] a,
                               input logic [17:0] d, input bit cm,
                               input logic [17:0] co, input bit tm,
                               input bit tv, input bit rw);
        vec_t r;
        r.we = we; r.a = a; r.d = d; r.cm = cm;
        r.co = co; r.tm = tm; r.tv = tv; r.rw = rw;
        return r;
    endfunction

    vec_t tbl [$];

    initial begin
        logic [17:0] val;
        logic [17:0] a;
        logic [17:0] d;
        logic [7:0]  exp_b [8];
        bit          rst;
        bit          we;
        bit          rdy;
        int          r;

        tbl.push_back(v(1, 18'h00010, 18'h12345, 0, 0,        1, 0, 1));
        tbl.push_back(v(0, 18'h00010, 0,         0, 0,        0, 0, 0));
        tbl.push_back(v(0, 18'h00000, 0,         1, 18'h12345, 0, 0, 0));
        tbl.push_back(v(1, 18'h3FFF3, 18'h2AAAA, 0, 0,        0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF3, 0,         0, 0,        0, 0, 0));
        tbl.push_back(v(0, 18'h00000, 0,         1, 18'h2AAAA, 0, 0, 0));
        tbl.push_back(v(1, 18'h3FFF2, 18'h3FFFE, 0, 0,        0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF2, 0,         0, 0,        0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF2, 0,         1, 18'h3FFFE, 0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF2, 0,         1, 18'h3FFFF, 0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF1, 0,         1, 18'h00000, 0, 0, 0));
        tbl.push_back(v(0, 18'h00000, 0,         1, 18'h00001, 0, 0, 0));
        tbl.push_back(v(1, 18'h3FFF2, 18'h00100, 1, 18'h00000, 0, 0, 0));
        tbl.push_back(v(0, 18'h00000, 0,         1, 18'h00003, 0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF2, 0,         1, 18'h00000, 0, 0, 0));
        tbl.push_back(v(0, 18'h00000, 0,         1, 18'h00101, 0, 0, 0));
        tbl.push_back(v(1, 18'h3FFF0, 18'h0005A, 0, 0,        1, 0, 0));
        tbl.push_back(v(0, 18'h3FFF0, 0,         1, 18'h00000, 1, 1, 0));
        tbl.push_back(v(0, 18'h3FFF5, 0,         1, 18'h00000, 1, 1, 0));
        tbl.push_back(v(1, 18'h3FFF5, 18'h3FFFF, 1, 18'h00000, 0, 0, 0));
        tbl.push_back(v(0, 18'h3FFF3, 0,         1, 18'h00000, 0, 0, 0));
        tbl.push_back(v(0, 18'h00000, 0,         1, 18'h2AAAA, 0, 0, 0));

        reset = 1; cpu_write_enable = 0; cpu_addr = '0; cpu_in = '0;
        tx_ready = 0;
        @(posedge clock);
        #1;
        step(1, 0, '0, '0, 0);
        step(1, 0, '0, '0, 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].we, tbl[i].a, tbl[i].d, 0);
            chk($sformatf("vec%0d_ram_we", i), o_rw, tbl[i].rw);
            if (tbl[i].cm) chk($sformatf("vec%0d_cpu_out", i), o_co, tbl[i].co);
            if (tbl[i].tm) chk($sformatf("vec%0d_tx_valid", i), o_tv, tbl[i].tv);
        end

        // Fill to full, then overflow, then clear the sticky flag.
        step(1, 0, '0, '0, 0);
        for (int b = 1; b <= 8; b++) wr(4'd0, 18'(b), 0);
        rd(4'd1, val);
        chk("status_full", val, 18'h42);
        wr(4'd0, 18'h9, 0);
        rd(4'd1, val);
        chk("status_ovf", val, 18'h46);
        chk("head_after_ovf", o_td, 8'h01);
        wr(4'd1, 18'h4, 0);
        rd(4'd1, val);
        chk("status_ovf_clr", val, 18'h42);

        // Full FIFO with push and pop in the same cycle.
        wr(4'd0, 18'hAA, 1);
        rd(4'd1, val);
        chk("status_pushpop", val, 18'h42);
        exp_b = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 18'h00020, '0, 1);
            chk($sformatf("pushpop_tv%0d", k), o_tv, 1'b1);
            chk($sformatf("pushpop_td%0d", k), o_td, exp_b[k]);
        end
        rd(4'd1, val);
        chk("status_drained", val, 18'h1);

        // Spread-out pushes drained immediately, crossing pointer wrap.
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 18'h3FFF0, 18'(8'h30 + k), 1);
            chk($sformatf("wrap_nofall%0d", k), o_tv, 1'b0);
            step(0, 0, 18'h00020, '0, 1);
            chk($sformatf("wrap_tv%0d", k), o_tv, 1'b1);
            chk($sformatf("wrap_td%0d", k), o_td, 8'(8'h30 + k));
        end
        rd(4'd1, val);
        chk("status_wrap_empty", val, 18'h1);

        // Reset with bytes queued and an I/O read in flight.
        step(0, 1, 18'h00020, 18'h0BEEF, 0);
        for (int k = 0; k < 5; k++) wr(4'd0, 18'(8'h70 + k), 0);
        step(0, 0, 18'h3FFF1, '0, 0);
        step(1, 0, 18'h00020, '0, 0);
        step(0, 0, 18'h3FFF2, '0, 0);
        chk("rst_tx_valid", o_tv, 1'b0);
        chk("rst_cpu_out_ram", o_co, 18'h0BEEF);
        step(0, 0, 18'h3FFF1, '0, 0);
        chk("rst_timer", o_co, 18'h0);
        step(0, 0, 18'h00020, '0, 0);
        chk("rst_status", o_co, 18'h1);

        // Random traffic against the model.
        step(1, 0, '0, '0, 0);
        for (int i = 0; i < 1500; i++) begin
            r   = int'($urandom_range(0, 199));
            rst = (r == 0);
            we  = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: a = 18'h3FFF0;
                    3:       a = 18'h3FFF1;
                    4:       a = 18'h3FFF2;
                    5:       a = 18'h3FFF3;
                    default: a = {14'h3FFF, 4'($urandom_range(4, 15))};
                endcase
            end else begin
                a = 18'($urandom);
            end
            d = 18'($urandom);
            if (a[3:0] == 4'd1 && $urandom_range(0, 3) != 0) d[2] = 1'b0;
            if ((i / 200) % 2 == 1) rdy = ($urandom_range(0, 15) == 0);
            else rdy = bit'($urandom_range(0, 1));
            step(rst, we, a, d, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
